// File: rtl/pipe_stage_buf_if.sv
// Handshake/payload bundle between two pipeline stages and the buffer sitting between them.
// Pure wiring, no latency of its own.
// Carries both the upstream valid/ready_go/allow_in and the downstream allow_in/valid pairs.
// Ports (slave = buffer view):
//   in : flush, up_valid, up_ready_go, up_data, stall, down_allow_in
//   out: allow_in, ready_go, out_valid, out_data, count
interface pipe_stage_buf_if #(
    parameter int DATA_W = 160
);
    logic              flush;
    logic              up_valid;
    logic              up_ready_go;
    logic [DATA_W-1:0] up_data;
    logic              allow_in;
    logic              stall;
    logic              ready_go;
    logic              down_allow_in;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        count;

    // Environment side: drives the stage controls and sees the buffer state.
    modport master (
        output flush, up_valid, up_ready_go, up_data, stall, down_allow_in,
        input  allow_in, ready_go, out_valid, out_data, count
    );

    // Buffer side.
    modport slave (
        input  flush, up_valid, up_ready_go, up_data, stall, down_allow_in,
        output allow_in, ready_go, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: opaque DATA_W payload held in a DEPTH-entry circular store.
// Latency 1 cycle: a pushed beat appears on out_valid/out_data on the next cycle (no bypass).
// Backpressure: DEPTH=1 allow_in is combinational from down_allow_in/stall; DEPTH>=2 allow_in is registered (count<DEPTH).
// Ports: clk, reset (async, active-low), bus (pipe_stage_buf_if.slave: flush, stall,
//        up_valid/up_ready_go/up_data -> allow_in, down_allow_in -> ready_go/out_valid/out_data/count).
module pipe_stage_buf #(
    parameter int                DATA_W   = 160,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_buf_if.slave bus
);
    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       FULL = 3'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic              out_valid;
    logic              ready_go;
    logic              allow_in;
    logic              push;
    logic              pop;

    assign out_valid = (count_q != 3'd0);
    assign ready_go  = !bus.stall;

    // A single-entry buffer must accept a new beat in the same cycle the old one
    // leaves, so its allow_in looks through to downstream. Deeper buffers use the
    // spare entry to cut that path and keep allow_in purely registered.
    generate
        if (DEPTH == 1) begin : g_comb_allow
            assign allow_in = !out_valid || (ready_go && bus.down_allow_in);
        end else begin : g_reg_allow
            assign allow_in = (count_q < FULL);
        end
    endgenerate

    // Flush kills both sides of the handshake in the cycle it is asserted.
    assign push = bus.up_valid && bus.up_ready_go && allow_in && !bus.flush;
    assign pop  = out_valid && ready_go && bus.down_allow_in && !bus.flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: an entry is only ever observed while count
    // covers it, and count is cleared by reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.up_data;
    end

    assign bus.allow_in  = allow_in;
    assign bus.ready_go  = ready_go;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : RST_DATA;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Exercises three buffers side by side (DEPTH 2, 3 and 1) against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Directed scenarios are followed by a randomized soak on all three buffers.
module tb_pipe_stage_buf;
    localparam int              DW  = 16;
    localparam int              NB  = 3;
    localparam logic [DW-1:0]   RST = 16'hDEAD;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          flush [NB];
    logic          up_valid [NB];
    logic          up_ready_go [NB];
    logic [DW-1:0] up_data [NB];
    logic          stall [NB];
    logic          down_allow_in [NB];
    logic          allow_in_w [NB];
    logic          ready_go_w [NB];
    logic          out_valid_w [NB];
    logic [DW-1:0] out_data_w [NB];
    logic [2:0]    count_w [NB];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq [NB][$];    // reference contents, head at index 0
    logic [DW-1:0] recv [NB][$];  // beats actually handed downstream
    int            maxcnt [NB];

    function automatic int dep_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 1;
    endfunction

    for (genvar k = 0; k < NB; k++) begin : g_dut
        pipe_stage_buf_if #(.DATA_W(DW)) bus ();
        assign bus.flush         = flush[k];
        assign bus.up_valid      = up_valid[k];
        assign bus.up_ready_go   = up_ready_go[k];
        assign bus.up_data       = up_data[k];
        assign bus.stall         = stall[k];
        assign bus.down_allow_in = down_allow_in[k];
        assign allow_in_w[k]     = bus.allow_in;
        assign ready_go_w[k]     = bus.ready_go;
        assign out_valid_w[k]    = bus.out_valid;
        assign out_data_w[k]     = bus.out_data;
        assign count_w[k]        = bus.count;

        pipe_stage_buf #(
            .DATA_W  (DW),
            .DEPTH   ((k == 0) ? 2 : (k == 1) ? 3 : 1),
            .RST_DATA(RST)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Space rule: one slot may be reused in the same cycle only by a single-entry buffer.
    function automatic bit model_allow(input int k);
        if (dep_of(k) == 1)
            return (mq[k].size() == 0) || (!stall[k] && down_allow_in[k]);
        return mq[k].size() < dep_of(k);
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < NB; k++) begin
            if (!reset) begin
                mq[k].delete();
            end else if (flush[k]) begin
                mq[k].delete();
            end else begin
                bit do_push;
                bit do_pop;
                do_push = up_valid[k] && up_ready_go[k] && model_allow(k);
                do_pop  = (mq[k].size() != 0) && !stall[k] && down_allow_in[k];
                if (do_pop)  void'(mq[k].pop_front());
                if (do_push) mq[k].push_back(up_data[k]);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NB; k++) begin
            int sz;
            sz = mq[k].size();
            check($sformatf("d%0d.out_valid", k), 32'(out_valid_w[k]), 32'(sz != 0));
            check($sformatf("d%0d.count", k), 32'(count_w[k]), 32'(sz));
            check($sformatf("d%0d.out_data", k), 32'(out_data_w[k]), 32'((sz != 0) ? mq[k][0] : RST));
            check($sformatf("d%0d.ready_go", k), 32'(ready_go_w[k]), 32'(!stall[k]));
            check($sformatf("d%0d.allow_in", k), 32'(allow_in_w[k]), 32'(model_allow(k)));
            if (reset && out_valid_w[k] && ready_go_w[k] && down_allow_in[k] && !flush[k])
                recv[k].push_back(out_data_w[k]);
            if (int'(count_w[k]) > maxcnt[k]) maxcnt[k] = int'(count_w[k]);
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < NB; k++) begin
            flush[k] = 0; up_valid[k] = 0; up_ready_go[k] = 1;
            up_data[k] = '0; stall[k] = 0; down_allow_in[k] = 1;
        end
    endtask

    task automatic check_recv(input string tag, input int k, input logic [DW-1:0] exp[$]);
        check({tag, ".len"}, 32'(recv[k].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < recv[k].size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(recv[k][i]), 32'(exp[i]));
        recv[k].delete();
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        int n_sent;

        // Reset held with traffic offered on every buffer.
        idle_all();
        for (int k = 0; k < NB; k++) begin
            up_valid[k] = 1; up_data[k] = 16'h1234 + 16'(k);
            maxcnt[k] = 0;
        end
        step(3);
        reset = 1'b1;
        idle_all();
        step(2);
        for (int k = 0; k < NB; k++) recv[k].delete();

        // Streaming through DEPTH=2.
        maxcnt[0] = 0;
        for (int i = 1; i <= 8; i++) begin
            up_valid[0] = 1; up_data[0] = 16'(i);
            step();
        end
        up_valid[0] = 0;
        step(3);
        exp_q = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
        check_recv("stream", 0, exp_q);
        check("stream.maxcount", 32'(maxcnt[0] <= 1), 32'd1);

        // Backpressure on DEPTH=2: C must wait until a slot frees.
        down_allow_in[0] = 0;
        up_valid[0] = 1; up_data[0] = 16'hA; step();
        up_data[0] = 16'hB; step();
        up_data[0] = 16'hC; step(3);
        check("bp.full_allow", 32'(allow_in_w[0]), 32'd0);
        check("bp.full_count", 32'(count_w[0]), 32'd2);
        down_allow_in[0] = 1;
        step(2);
        up_valid[0] = 0;
        step(4);
        exp_q = '{16'hA, 16'hB, 16'hC};
        check_recv("bp", 0, exp_q);

        // Flush with a full buffer and a beat offered in the same cycle.
        down_allow_in[0] = 0;
        up_valid[0] = 1; up_data[0] = 16'h1; step();
        up_data[0] = 16'h2; step();
        up_data[0] = 16'hD; flush[0] = 1; step();
        flush[0] = 0; up_valid[0] = 0;
        check("flush.count", 32'(count_w[0]), 32'd0);
        check("flush.valid", 32'(out_valid_w[0]), 32'd0);
        down_allow_in[0] = 1;
        step(3);
        exp_q = {};
        check_recv("flush", 0, exp_q);

        // DEPTH=3 wrap with random downstream availability.
        exp_q = {};
        n_sent = 0;
        for (int i = 0; i < 40 && n_sent < 10; i++) begin
            down_allow_in[1] = 1'($urandom_range(0, 1));
            up_valid[1] = 1; up_data[1] = 16'h100 + 16'(n_sent);
            #3;
            if (allow_in_w[1]) begin
                exp_q.push_back(up_data[1]);
                n_sent++;
            end
            step();
        end
        up_valid[1] = 0; down_allow_in[1] = 1;
        step(5);
        check("wrap.sent", 32'(n_sent), 32'd10);
        check_recv("wrap", 1, exp_q);

        // DEPTH=1 same-cycle replacement.
        down_allow_in[2] = 0;
        up_valid[2] = 1; up_data[2] = 16'h7; step();
        up_data[2] = 16'h5; down_allow_in[2] = 1; stall[2] = 0;
        #2;
        check("d1.replace_allow", 32'(allow_in_w[2]), 32'd1);
        step();
        up_valid[2] = 0; down_allow_in[2] = 0;
        check("d1.replace_count", 32'(count_w[2]), 32'd1);
        check("d1.replace_data", 32'(out_data_w[2]), 32'h5);
        down_allow_in[2] = 1;
        step(2);
        exp_q = '{16'h7, 16'h5};
        check_recv("d1", 2, exp_q);

        // Randomized soak on all three buffers.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NB; k++) begin
                up_valid[k]      = ($urandom_range(0, 3) != 0);
                up_ready_go[k]   = ($urandom_range(0, 4) != 0);
                up_data[k]       = 16'($urandom);
                stall[k]         = ($urandom_range(0, 5) == 0);
                down_allow_in[k] = ($urandom_range(0, 2) != 0);
                flush[k]         = ($urandom_range(0, 24) == 0);
            end
            step();
        end

        // Reset in the middle of a transfer clears everything at once.
        for (int k = 0; k < NB; k++) begin
            flush[k] = 0; stall[k] = 0; down_allow_in[k] = 0;
            up_valid[k] = 1; up_ready_go[k] = 1; up_data[k] = 16'h0BAD;
        end
        step(2);
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < NB; k++) begin
            check($sformatf("arst.d%0d.valid", k), 32'(out_valid_w[k]), 32'd0);
            check($sformatf("arst.d%0d.data", k), 32'(out_data_w[k]), 32'(RST));
        end
        step(2);
        idle_all();
        reset = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
